// File: rtl/tx_queue.sv
// Circular byte FIFO that paces a producer's single-cycle byte strobes into the
// uart_tx valid/done handshake, launching one byte at a time.
module tx_queue #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            i_byte,
  input  logic                  i_byte_v,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [DEPTH_LOG2:0]   o_count,
  output logic                  o_overflow,
  output logic [7:0]            o_byte,
  output logic                  o_byte_v,
  input  logic                  i_tx_active,
  input  logic                  i_tx_done
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   COUNT_ONE  = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = DEPTH_LOG2'(1);

  typedef enum logic {
    IDLE,
    SENT
  } state_t;

  state_t                  state_reg, state_next;
  logic [7:0]              mem [DEPTH];
  logic [DEPTH_LOG2-1:0]   wp_reg, rp_reg;
  logic [DEPTH_LOG2:0]     count_reg, count_next;
  logic                    push, pop;

  // Full/empty decode the registered count, so a write while full is dropped
  // even when a pop happens on the same edge.
  assign o_full  = (count_reg == FULL_COUNT);
  assign o_empty = (count_reg == '0);
  assign o_count = count_reg;
  assign push    = i_byte_v && !o_full;

  always_comb begin
    state_next = state_reg;
    pop        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!o_empty && !i_tx_active) begin
          pop        = 1'b1;
          state_next = SENT;
        end
      end
      SENT: begin
        if (i_tx_done) state_next = IDLE;
      end
    endcase
  end

  always_comb begin
    count_next = count_reg;
    if (push && !pop) begin
      count_next = count_reg + COUNT_ONE;
    end else if (pop && !push) begin
      count_next = count_reg - COUNT_ONE;
    end
  end

  // Storage is never reset; stale contents are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (push) mem[wp_reg] <= i_byte;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      wp_reg     <= '0;
      rp_reg     <= '0;
      count_reg  <= '0;
      o_byte     <= 8'h00;
      o_byte_v   <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      state_reg  <= state_next;
      count_reg  <= count_next;
      o_byte_v   <= pop;
      o_overflow <= i_byte_v && o_full;
      if (push) wp_reg <= wp_reg + PTR_ONE;
      if (pop) begin
        rp_reg <= rp_reg + PTR_ONE;
        o_byte <= mem[rp_reg];
      end
    end
  end

endmodule

// File: tb/tb_tx_queue.sv
// Randomised bench for tx_queue: a queue-based reference model predicts every
// output each cycle while a small uart_tx stand-in answers the launch strobes.
module tb_tx_queue;

  localparam int DL    = 4;
  localparam int DEPTH = 2 ** DL;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    i_byte = 8'h00;
  logic          i_byte_v = 1'b0;
  logic          i_tx_active = 1'b0;
  logic          i_tx_done = 1'b0;
  logic          o_full, o_empty, o_overflow, o_byte_v;
  logic [DL:0]   o_count;
  logic [7:0]    o_byte;

  tx_queue #(.DEPTH_LOG2(DL)) dut (
    .clk(clk), .rst(rst),
    .i_byte(i_byte), .i_byte_v(i_byte_v),
    .o_full(o_full), .o_empty(o_empty), .o_count(o_count),
    .o_overflow(o_overflow), .o_byte(o_byte), .o_byte_v(o_byte_v),
    .i_tx_active(i_tx_active), .i_tx_done(i_tx_done)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [7:0] mq[$];
  bit         m_wait = 0;
  bit         m_ovf = 0;
  bit         m_v = 0;
  logic [7:0] m_byte = 8'h00;

  // uart_tx stand-in
  bit hold = 0;
  bit uart_busy = 0;
  int uart_cnt = 0;
  int uart_min = 2;
  int uart_max = 10;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Called at a falling edge: drive inputs for the next rising edge, advance
  // the model across that edge, then check outputs at the following fall.
  task automatic step(input bit v, input logic [7:0] b, input bit r, input bit stray);
    bit done_n;
    bit full;
    done_n = 0;
    if (uart_busy) begin
      if (uart_cnt == 0) begin
        uart_busy = 0;
        done_n    = 1;
      end else begin
        uart_cnt--;
      end
    end else if (o_byte_v === 1'b1) begin
      uart_busy = 1;
      uart_cnt  = $urandom_range(uart_max, uart_min);
    end else if (stray) begin
      done_n = 1;
    end
    i_tx_done   = done_n;
    i_tx_active = uart_busy | hold;
    i_byte_v    = v;
    i_byte      = b;
    rst         = r;

    if (r) begin
      mq.delete();
      m_wait = 0;
      m_ovf  = 0;
      m_v    = 0;
      m_byte = 8'h00;
    end else begin
      full  = (mq.size() == DEPTH);
      m_ovf = v && full;
      m_v   = 0;
      if (!m_wait) begin
        if (mq.size() > 0 && !i_tx_active) begin
          m_byte = mq.pop_front();
          m_v    = 1;
          m_wait = 1;
        end
      end else if (i_tx_done) begin
        m_wait = 0;
      end
      if (v && !full) mq.push_back(b);
    end

    @(negedge clk);
    check("count",    32'(o_count),    32'(mq.size()));
    check("empty",    32'(o_empty),    32'(mq.size() == 0));
    check("full",     32'(o_full),     32'(mq.size() == DEPTH));
    check("overflow", 32'(o_overflow), 32'(m_ovf));
    check("byte_v",   32'(o_byte_v),   32'(m_v));
    check("byte",     32'(o_byte),     32'(m_byte));
    if (o_byte_v === 1'b1) $display("launch byte %02h at %0t", o_byte, $time);
  endtask

  task automatic drain();
    for (int i = 0; i < 3000 && (mq.size() > 0 || m_wait); i++) step(0, 8'h00, 0, 0);
    check("drain_left", 32'(mq.size()), 32'(0));
  endtask

  initial begin
    // Reset and idle
    step(0, 8'h00, 1, 0);
    step(0, 8'h00, 1, 0);
    for (int i = 0; i < 20; i++) step(0, 8'h00, 0, 0);

    // Single byte: strobe two cycles later, no second strobe until done
    step(1, 8'h41, 0, 0);
    drain();
    for (int i = 0; i < 5; i++) step(0, 8'h00, 0, 0);

    // Ordered burst with pointer wrap, paced below full
    for (int i = 0; i < 20; i++) begin
      step(1, 8'(i), 0, 0);
      while (mq.size() > 8) step(0, 8'h00, 0, 0);
    end
    drain();

    // Overflow while the UART is held busy
    hold = 1;
    for (int i = 0; i < 17; i++) step(1, 8'(8'hA0 + i), 0, 0);
    step(0, 8'h00, 0, 0);
    step(0, 8'h00, 0, 0);
    hold = 0;
    drain();

    // Reset mid-frame with bytes queued and the UART still busy
    uart_min = 30;
    uart_max = 30;
    for (int i = 0; i < 6; i++) step(1, 8'(8'h10 + i), 0, 0);
    step(0, 8'h00, 0, 0);
    check("mid_queued", 32'(o_count), 32'(5));
    step(0, 8'h00, 1, 0);
    for (int i = 0; i < 4; i++) step(0, 8'h00, 0, 0);
    step(1, 8'h55, 0, 0);
    drain();
    for (int i = 0; i < 5; i++) step(0, 8'h00, 0, 0);
    uart_min = 2;
    uart_max = 10;

    // Randomised phases: varied write rates, stalls, stray done pulses, resets
    for (int ph = 0; ph < 8; ph++) begin
      int rate;
      rate = $urandom_range(90, 10);
      for (int c = 0; c < 400; c++) begin
        if ($urandom_range(0, 49) == 0) hold = ~hold;
        step($urandom_range(0, 99) < rate, 8'($urandom), $urandom_range(0, 399) == 0,
             $urandom_range(0, 19) == 0);
      end
      hold = 0;
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
